// File: rtl/modn_counter_sync.sv
// Parametrised synchronous modulo-N counter with start/stop control,
// up/down counting, clamped parallel load, one-shot or free-run mode,
// a combinational terminal-count flag and a registered wrap pulse.
// Count range is 0..MODULUS-1; q never leaves that range.
module modn_counter_sync #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 6
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             wrap
);

    // Reject a modulus the count register cannot represent.
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("modn_counter_sync: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q_next;
    logic             at_term;
    logic             count_step;
    logic             wrap_evt;

    // busy is the state itself, so the FSM state is always observable.
    assign busy = (state == RUN);

    // Terminal value depends on direction: top when counting up, zero when down.
    assign at_term = up ? (q == MAX_VAL) : (q == ZERO);

    // A stop edge holds q, so counting is suppressed while stop is asserted.
    assign count_step = busy & en & ~load & ~stop;
    assign wrap_evt   = count_step & at_term;

    // Cascade output: high in the cycle before the wrap edge.
    assign tc = busy & en & ~load & at_term;

    // Next-state and next-count logic; load overrides counting, state is independent of load.
    always_comb begin
        state_next = state;
        q_next     = q;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (oneshot && wrap_evt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            q_next = (d > MAX_VAL) ? MAX_VAL : d;
        end else if (count_step) begin
            if (up) begin
                q_next = (q == MAX_VAL) ? ZERO : (q + ONE);
            end else begin
                q_next = (q == ZERO) ? MAX_VAL : (q - ONE);
            end
        end
    end

    // State, count and wrap-pulse registers with asynchronous clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            q     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            wrap  <= wrap_evt;
        end
    end

endmodule

// File: tb/tb_modn_counter_sync.sv
// Bench for modn_counter_sync: three instances (4/6, 3/8, 5/10) share the
// control inputs; expected {q, busy, tc, wrap} tuples are queued as each
// stimulus cycle is driven and popped when the DUT output is sampled.
module tb_modn_counter_sync;

    localparam int W = 8;

    logic       clk;
    logic       nrst;
    logic       start;
    logic       stop;
    logic       en;
    logic       up;
    logic       oneshot;
    logic       load;
    logic [4:0] d;

    logic [3:0] q0;
    logic       busy0, tc0, wrap0;
    logic [2:0] q1;
    logic       busy1, tc1, wrap1;
    logic [4:0] q2;
    logic       busy2, tc2, wrap2;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    modn_counter_sync #(.WIDTH(4), .MODULUS(6)) dut0 (
        .clk(clk), .nrst(nrst), .start(start), .stop(stop), .en(en), .up(up),
        .oneshot(oneshot), .load(load), .d(d[3:0]),
        .q(q0), .busy(busy0), .tc(tc0), .wrap(wrap0)
    );

    modn_counter_sync #(.WIDTH(3), .MODULUS(8)) dut1 (
        .clk(clk), .nrst(nrst), .start(start), .stop(stop), .en(en), .up(up),
        .oneshot(oneshot), .load(load), .d(d[2:0]),
        .q(q1), .busy(busy1), .tc(tc1), .wrap(wrap1)
    );

    modn_counter_sync #(.WIDTH(5), .MODULUS(10)) dut2 (
        .clk(clk), .nrst(nrst), .start(start), .stop(stop), .en(en), .up(up),
        .oneshot(oneshot), .load(load), .d(d),
        .q(q2), .busy(busy2), .tc(tc2), .wrap(wrap2)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation of one instance: {q, busy, tc, wrap}
    function automatic logic [W-1:0] obs(input int sel);
        case (sel)
            0:       obs = {5'(q0), busy0, tc0, wrap0};
            1:       obs = {5'(q1), busy1, tc1, wrap1};
            default: obs = {q2, busy2, tc2, wrap2};
        endcase
    endfunction

    function automatic logic [W-1:0] pack(input int qv, input logic b, input logic t, input logic w);
        pack = {5'(qv), b, t, w};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; en = 1'b0; up = 1'b1;
        oneshot = 1'b0; load = 1'b0; d = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] got, exp;
        idle_inputs();
        nrst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            got = obs(s);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset_inst%0d: got %h expected %h", s, got, exp);
            end
        end
        #2;
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            en = k[0];
            up = k[1];
            exp_q.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            tick();
            got = obs(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL idle_no_start cycle %0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_oneshot(input int sel, input int m);
        logic [W-1:0] got, exp;
        do_reset();
        en = 1'b1; up = 1'b1; oneshot = 1'b1; start = 1'b1;
        for (int k = 0; k <= m + 1; k++) begin
            if (k == 0)
                exp_q.push_back(pack(0, 1'b1, 1'b0, 1'b0));
            else if (k < m)
                exp_q.push_back(pack(k, 1'b1, (k == m - 1), 1'b0));
            else if (k == m)
                exp_q.push_back(pack(0, 1'b0, 1'b0, 1'b1));
            else
                exp_q.push_back(pack(0, 1'b0, 1'b0, 1'b0));
            tick();
            if (k == 0) start = 1'b0;
            got = obs(sel);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL oneshot_m%0d step %0d: got %h expected %h", m, k, got, exp);
            end
        end
    endtask

    task automatic test_freerun_down_stall();
        logic [W-1:0] got, exp;
        int seq[8] = '{5, 4, 3, 2, 1, 0, 5, 4};
        do_reset();
        up = 1'b0; oneshot = 1'b0; en = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pack(0, 1'b1, 1'b0, 1'b0));
            tick();
            start = 1'b0;
            got = obs(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL down_stall cycle %0d: got %h expected %h", k, got, exp);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(pack(seq[k], 1'b1, (seq[k] == 0), (seq[k] == 5)));
            tick();
            got = obs(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL down_count step %0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [W-1:0] got, exp;
        // per-step stimulus {load, en, stop, d} and expected tuple
        logic       ld_t[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       en_t[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       st_t[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int         d_t[7]   = '{3, 9, 2, 0, 5, 0, 4};
        int         eq_t[7]  = '{3, 5, 2, 3, 5, 5, 4};
        logic       eb_t[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        up = 1'b1; oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            load = ld_t[k]; en = en_t[k]; stop = st_t[k]; d = 5'(d_t[k]);
            // tc is sampled with the same inputs still applied after the edge
            exp_q.push_back(pack(eq_t[k], eb_t[k],
                                 eb_t[k] & en_t[k] & ~ld_t[k] & (eq_t[k] == 5), 1'b0));
            tick();
            got = obs(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL load_clamp step %0d: got %h expected %h", k, got, exp);
            end
        end
        load = 1'b0; stop = 1'b0;
    endtask

    task automatic test_load_terminal_no_wrap();
        logic [W-1:0] got, exp;
        do_reset();
        up = 1'b1; oneshot = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        load = 1'b1; d = 5'd5;
        exp_q.push_back(pack(5, 1'b1, 1'b0, 1'b0));
        tick();
        load = 1'b0;
        #1;
        got = obs(0);
        exp = exp_q.pop_front();
        n_checks++;
        if (got[7:3] !== exp[7:3] || got[0] !== exp[0] || got[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL load_terminal: got %h expected q/wrap %h with tc=1", got, exp);
        end
        exp_q.push_back(pack(0, 1'b1, 1'b0, 1'b1));
        tick();
        got = obs(0);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL wrap_after_load: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_stop_start();
        logic [W-1:0] got, exp;
        logic st_t[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic sp_t[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int   eq_t[9] = '{0, 0, 1, 2, 2, 2, 2, 3, 4};
        logic eb_t[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        up = 1'b1; oneshot = 1'b0; en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            start = st_t[k]; stop = sp_t[k];
            exp_q.push_back(pack(eq_t[k], eb_t[k], 1'b0, 1'b0));
            tick();
            got = obs(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL stop_start step %0d: got %h expected %h", k, got, exp);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_async_reset_mid();
        logic [W-1:0] got, exp;
        do_reset();
        up = 1'b1; oneshot = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        exp_q.push_back(pack(4, 1'b1, 1'b0, 1'b0));
        got = obs(0);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL pre_reset_count: got %h expected %h", got, exp);
        end
        #2;
        nrst = 1'b0;
        exp_q.push_back(pack(0, 1'b0, 1'b0, 1'b0));
        #1;
        got = obs(0);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL async_reset_mid: got %h expected %h", got, exp);
        end
        #1;
        nrst = 1'b1;
    endtask

    task automatic test_direction_change();
        logic [W-1:0] got, exp;
        logic up_t[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int   eq_t[6] = '{1, 2, 1, 0, 5, 0};
        do_reset();
        oneshot = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            up = up_t[k];
            exp_q.push_back(pack(eq_t[k], 1'b1,
                                 up_t[k] ? (eq_t[k] == 5) : (eq_t[k] == 0),
                                 (k == 4) || (k == 5)));
            tick();
            got = obs(0);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL direction step %0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_oneshot(0, 6);
        test_freerun_down_stall();
        test_load_clamp();
        test_load_terminal_no_wrap();
        test_stop_start();
        test_async_reset_mid();
        test_direction_change();
        test_oneshot(1, 8);
        test_oneshot(2, 10);
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
